pulse_receiver: RTL and testbench
=================================

Name: pulse_receiver

Overview:
- Receive-side counterpart of the team's pulse generator. Observes an external pulse train on one input line, e.g. a bus clock or strobe seen by the MITM tap.
- Synchronises and deglitches the line, then counts qualified pulses after being armed.
- Reports completion once CYCLE_COUNT pulses are seen, or a timeout with a partial count if the line goes quiet or sticks active.
- Sits between the input pins and the protocol-decoding state machines; edge_strb serves as their sample strobe.

Parameters:
- CYCLE_COUNT, 8: pulses expected per frame.
- TIMEOUT, 64: sys_clk cycles without a qualifying event before the frame is abandoned (>=1).
- MIN_PULSE_LEN, 1: consecutive active synchronised samples required to qualify a pulse (>=1).
- SYNC_STAGES, 2: synchroniser flops on in_sig (>=2).
- ACTIVE_LOW, 0: 1 means in_sig is passive high and the pulse is low.
- PERIOD_W, 16: width of the period measurement output.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_sig  in  1  external asynchronous pulse line.
- start  in  1  arm request, one-cycle pulse.
- busy  out  1  high in ARMED or RECEIVE.
- edge_strb  out  1  one-cycle strobe per qualified pulse.
- pulse_cnt  out  $clog2(CYCLE_COUNT+1)  pulses counted in the current or last frame.
- done_sig  out  1  frame finished; held until the next accepted start.
- timeout_sig  out  1  last frame ended by timeout; valid while done_sig=1.
- last_period  out  PERIOD_W  sys_clk cycles between the last two qualified pulses (optional feature).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, edge_strb=0, pulse_cnt=0, timeout_sig=0, last_period=0.
  - done_sig=1 (block idle and ready).
  - Sync flops and qualifier load the passive level.
- Synchroniser and qualifier:
  - in_sig passes through SYNC_STAGES flops, giving level s.
  - A run counter counts consecutive active s samples and clears on passive.
  - A pulse qualifies when the run reaches MIN_PULSE_LEN, and only if s was passive at some point since the previous qualification or since arming. A level already active when armed is not counted.
  - Latency: edge_strb is high in the cycle after sys_clk edge number SYNC_STAGES+MIN_PULSE_LEN, counting the edge that first samples the active in_sig as edge 1.
  - A glitch shorter than MIN_PULSE_LEN samples produces no strobe and no count change.
- States:
  - IDLE: qualified pulses are ignored (no edge_strb). On start: done_sig<=0, timeout_sig<=0, pulse_cnt<=0, passive-seen flag<=0, go to ARMED.
  - ARMED: waits indefinitely for the first qualified pulse. On it: edge_strb, pulse_cnt<=1, idle_ctr<=0, go to RECEIVE.
  - RECEIVE:
    - idle_ctr increments each cycle and clears on each qualified pulse.
    - On a qualified pulse with pulse_cnt<CYCLE_COUNT: edge_strb, pulse_cnt++.
    - When pulse_cnt==CYCLE_COUNT and s returns passive: done_sig<=1, timeout_sig<=0, go to IDLE.
    - When idle_ctr reaches TIMEOUT (including a line stuck active after the final pulse): done_sig<=1, timeout_sig<=1, pulse_cnt frozen, go to IDLE.
  - If timeout and completion occur in the same cycle, completion wins (timeout_sig=0).
- Boundary rules:
  - start while busy is ignored.
  - start in the same cycle done_sig rises is ignored; it is accepted from the next cycle.
  - pulse_cnt never exceeds CYCLE_COUNT; further pulses in RECEIVE after the count is reached are not strobed.
  - idle_ctr saturates at TIMEOUT.
  - Counters use exact clog2 widths; no wrap-around anywhere.
  - rst_n mid-frame aborts immediately to the reset values.

Optional Feature:
- Macro: PULSE_RECEIVER_PERIOD_MEASURE_EN.
- Defined:
  - A PERIOD_W counter runs from each qualified pulse.
  - On the next qualified pulse in RECEIVE, last_period<=counter value and the counter restarts.
  - The counter saturates at all-ones.
  - last_period is cleared on accepted start.
- Undefined: last_period is tied to 0 and no counter is synthesised. The port list is identical in both builds.

Decomposition:
- Shared package pulse_pkg holds:
  - state encodings IDLE/ARMED/RECEIVE (2-bit), shared with the generator's encodings;
  - a passive-level constant derived from ACTIVE_LOW;
  - the counter-width helper, clog2(N+1).
- One sub-module, pulse_sync_filter: synchroniser, run counter, passive-seen flag and qualify-strobe output.
- The top holds the FSM, counters and the optional period logic.

Test Plan:
- Defaults; arm, then 8 pulses of 3 clk active / 9 clk passive:
  - 8 edge_strb, each 3 clks after the in_sig rise;
  - done_sig=1 about 3 clks after the 8th fall;
  - pulse_cnt=8, timeout_sig=0.
- Arm, send 5 pulses, then hold passive: done_sig=1 exactly 64 clks after the 5th strobe, timeout_sig=1, pulse_cnt=5.
- MIN_PULSE_LEN=3; pulses of 2 clk and then 4 clk: only the 4-clk pulse strobes, pulse_cnt=1.
- in_sig already active at start, falls then rises: the first active period is not counted and the second is (pulse_cnt=1). A pulse in IDLE gives no strobe.
- Assert rst_n=0 mid-frame at pulse 4: outputs take reset values asynchronously. start pulsed during busy has no effect.
- With the macro defined, pulses spaced 12 clks apart give last_period=12. Without the macro, last_period stays 0.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator/receiver pair: FSM encodings,
// passive line level and counter width helper.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RECEIVE = 2'd2
  } state_t;

  // Idle level of the line: high when the pulse polarity is active-low.
  function automatic logic passive_lvl(input int active_low);
    return (active_low != 0);
  endfunction

  // Width able to hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pulse_sync_filter.sv
// Synchroniser and pulse qualifier: brings in_sig into the sys_clk domain and
// raises qual once per active run of at least MIN_PULSE_LEN samples.
module pulse_sync_filter
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_PULSE_LEN = 1,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic in_sig,
  input  logic arm,
  output logic active,
  output logic qual
);

  localparam logic          PASSIVE = passive_lvl(ACTIVE_LOW);
  localparam int            RW      = cnt_w(MIN_PULSE_LEN);
  localparam logic [RW-1:0] RUN_MAX = RW'(MIN_PULSE_LEN);
  localparam logic [RW-1:0] RUN_HIT = RW'(MIN_PULSE_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [RW-1:0]          run;
  logic                   passive_seen;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{PASSIVE}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], in_sig};
  end

  assign active = (sync_q[SYNC_STAGES-1] != PASSIVE);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)              run <= '0;
    else if (!active)        run <= '0;
    else if (run != RUN_MAX) run <= run + 1'b1;
  end

  // A level already active when armed must go passive before it can count.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)           passive_seen <= 1'b0;
    else if (arm || qual) passive_seen <= 1'b0;
    else if (!active)     passive_seen <= 1'b1;
  end

  assign qual = active && (run == RUN_HIT) && passive_seen;

endmodule

// File: rtl/pulse_receiver.sv
// Pulse train receiver: counts qualified pulses per armed frame, ends on count
// or inactivity timeout. PULSE_RECEIVER_PERIOD_MEASURE_EN adds period capture.
module pulse_receiver
  import pulse_pkg::*;
#(
  parameter int CYCLE_COUNT   = 8,
  parameter int TIMEOUT       = 64,
  parameter int MIN_PULSE_LEN = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int ACTIVE_LOW    = 0,
  parameter int PERIOD_W      = 16
) (
  input  logic                          sys_clk,
  input  logic                          rst_n,
  input  logic                          in_sig,
  input  logic                          start,
  output logic                          busy,
  output logic                          edge_strb,
  output logic [cnt_w(CYCLE_COUNT)-1:0] pulse_cnt,
  output logic                          done_sig,
  output logic                          timeout_sig,
  output logic [PERIOD_W-1:0]           last_period
);

  localparam int            CW       = cnt_w(CYCLE_COUNT);
  localparam int            IW       = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CYCLE_COUNT);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);
  localparam logic [IW-1:0] IDLE_HIT = IW'(TIMEOUT - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt_n;
  logic [IW-1:0] idle_ctr, idle_n;
  logic          done_n, tmo_n, strb_n;
  logic          fin, accept, active, qual;

  // fin marks the first cycle after a frame ends; start is not taken there.
  assign accept = (state == IDLE) && start && !fin;
  assign busy   = (state != IDLE);

  pulse_sync_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .MIN_PULSE_LEN(MIN_PULSE_LEN),
    .ACTIVE_LOW   (ACTIVE_LOW)
  ) u_filt (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .in_sig (in_sig),
    .arm    (accept),
    .active (active),
    .qual   (qual)
  );

  always_comb begin
    state_n = state;
    cnt_n   = pulse_cnt;
    idle_n  = idle_ctr;
    done_n  = done_sig;
    tmo_n   = timeout_sig;
    strb_n  = 1'b0;
    case (state)
      IDLE: if (accept) begin
        done_n  = 1'b0;
        tmo_n   = 1'b0;
        cnt_n   = '0;
        state_n = ARMED;
      end
      ARMED: if (qual) begin
        strb_n  = 1'b1;
        cnt_n   = CW'(1);
        idle_n  = '0;
        state_n = RECEIVE;
      end
      RECEIVE: begin
        if (idle_ctr != IDLE_MAX) idle_n = idle_ctr + 1'b1;
        if (qual) begin
          idle_n = '0;
          if (pulse_cnt < CNT_MAX) begin
            strb_n = 1'b1;
            cnt_n  = pulse_cnt + 1'b1;
          end
        end
        // Completion is checked first so it wins over a coincident timeout.
        if (pulse_cnt == CNT_MAX && !active) begin
          done_n  = 1'b1;
          tmo_n   = 1'b0;
          state_n = IDLE;
        end else if (!qual && idle_ctr == IDLE_HIT) begin
          done_n  = 1'b1;
          tmo_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pulse_cnt   <= '0;
      idle_ctr    <= '0;
      done_sig    <= 1'b1;
      timeout_sig <= 1'b0;
      edge_strb   <= 1'b0;
      fin         <= 1'b0;
    end else begin
      state       <= state_n;
      pulse_cnt   <= cnt_n;
      idle_ctr    <= idle_n;
      done_sig    <= done_n;
      timeout_sig <= tmo_n;
      edge_strb   <= strb_n;
      fin         <= (state == RECEIVE) && (state_n == IDLE);
    end
  end

`ifdef PULSE_RECEIVER_PERIOD_MEASURE_EN
  logic [PERIOD_W-1:0] per_ctr;

  // Restart at 1 so the captured value equals the cycle distance.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      per_ctr     <= '0;
      last_period <= '0;
    end else begin
      if (qual && state != IDLE) per_ctr <= PERIOD_W'(1);
      else if (per_ctr != '1)    per_ctr <= per_ctr + 1'b1;
      if (accept)                          last_period <= '0;
      else if (qual && state == RECEIVE)   last_period <= per_ctr;
    end
  end
`else
  assign last_period = '0;
`endif

endmodule

// File: tb/tb_pulse_receiver.sv
// Directed bench for pulse_receiver: default instance plus a MIN_PULSE_LEN=3 copy.
module tb_pulse_receiver;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        in_sig  = 1'b0;
  logic        start   = 1'b0;
  logic        start3  = 1'b0;
  logic        busy, edge_strb, done_sig, timeout_sig;
  logic [3:0]  pulse_cnt;
  logic [15:0] last_period;
  logic        busy3, edge_strb3, done_sig3, timeout_sig3;
  logic [3:0]  pulse_cnt3;
  logic [15:0] last_period3;

  int checks = 0, failures = 0;
  int strb = 0, strb3 = 0, s0 = 0, s30 = 0;

`ifdef PULSE_RECEIVER_PERIOD_MEASURE_EN
  localparam logic [15:0] EXP_PER = 16'd12;
`else
  localparam logic [15:0] EXP_PER = 16'd0;
`endif

  always #5 sys_clk = ~sys_clk;

  pulse_receiver u_dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .in_sig(in_sig), .start(start),
    .busy(busy), .edge_strb(edge_strb), .pulse_cnt(pulse_cnt),
    .done_sig(done_sig), .timeout_sig(timeout_sig), .last_period(last_period)
  );

  pulse_receiver #(.MIN_PULSE_LEN(3)) u3 (
    .sys_clk(sys_clk), .rst_n(rst_n), .in_sig(in_sig), .start(start3),
    .busy(busy3), .edge_strb(edge_strb3), .pulse_cnt(pulse_cnt3),
    .done_sig(done_sig3), .timeout_sig(timeout_sig3), .last_period(last_period3)
  );

  always @(posedge sys_clk) begin
    if (edge_strb)  strb++;
    if (edge_strb3) strb3++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Drive one pulse from a negedge; check u_dut strobe lat negedges after the rise.
  task automatic send(input int act, input int pas, input logic exp, input int lat);
    in_sig = 1'b1;
    for (int i = 1; i <= act + pas; i++) begin
      @(negedge sys_clk);
      if (i == lat) check("strobe_latency", edge_strb, exp);
      if (i == act) in_sig = 1'b0;
    end
  endtask

  initial begin
    // reset values
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_strb", edge_strb, 0);
    check("rst_cnt", pulse_cnt, 0);
    check("rst_done", done_sig, 1);
    check("rst_tmo", timeout_sig, 0);
    check("rst_per", last_period, 0);
    rst_n = 1'b1;
    tick(3);

    // full frame of 8 pulses, 3 active / 9 passive
    s0 = strb;
    start = 1'b1; tick(1); start = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_done", done_sig, 0);
    repeat (7) send(3, 9, 1'b1, 3);
    send(3, 2, 1'b1, 3);
    check("done_not_yet", done_sig, 0);
    tick(1);
    check("done_after_fall", done_sig, 1);
    check("full_cnt", pulse_cnt, 8);
    check("full_tmo", timeout_sig, 0);
    check("full_busy", busy, 0);
    check("full_strobes", strb - s0, 8);
    check("full_period", last_period, EXP_PER);

    // start in the cycle done rises is dropped, taken on the next
    start = 1'b1; tick(1);
    check("start_on_done_ignored", busy, 0);
    tick(1); start = 1'b0;
    check("start_next_taken", busy, 1);
    check("rearm_done", done_sig, 0);
    check("rearm_cnt", pulse_cnt, 0);
    check("rearm_per_clr", last_period, 0);

    // 5 pulses then quiet: timeout 64 cycles after the 5th strobe
    s0 = strb;
    repeat (5) send(3, 9, 1'b1, 3);
    start = 1'b1; tick(1); start = 1'b0;
    check("busy_start_ignored", busy, 1);
    check("busy_start_cnt", pulse_cnt, 5);
    tick(53);
    check("tmo_not_yet", done_sig, 0);
    tick(1);
    check("tmo_done", done_sig, 1);
    check("tmo_flag", timeout_sig, 1);
    check("tmo_cnt", pulse_cnt, 5);
    check("tmo_strobes", strb - s0, 5);

    // MIN_PULSE_LEN=3 copy: 2-clk glitch rejected, 4-clk pulse counted
    s0 = strb; s30 = strb3;
    start3 = 1'b1; tick(1); start3 = 1'b0;
    check("m3_busy", busy3, 1);
    send(2, 9, 1'b0, 3);
    send(4, 9, 1'b0, 3);
    check("m3_cnt", pulse_cnt3, 1);
    check("m3_strobes", strb3 - s30, 1);
    check("idle_no_strobe", strb - s0, 0);
    check("idle_cnt_frozen", pulse_cnt, 5);
    check("idle_tmo_held", timeout_sig, 1);

    // line already active at arm is not counted
    in_sig = 1'b1; tick(4);
    s0 = strb;
    start = 1'b1; tick(1); start = 1'b0;
    check("act_arm_busy", busy, 1);
    tick(5);
    check("act_arm_cnt", pulse_cnt, 0);
    check("act_arm_strobes", strb - s0, 0);
    in_sig = 1'b0; tick(5);
    send(3, 9, 1'b1, 3);
    check("act_arm_second", pulse_cnt, 1);
    check("act_arm_strobes2", strb - s0, 1);

    // asynchronous reset in the middle of pulse 5
    repeat (3) send(3, 9, 1'b1, 3);
    check("mid_cnt", pulse_cnt, 4);
    check("mid_period", last_period, EXP_PER);
    in_sig = 1'b1; tick(1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_strb", edge_strb, 0);
    check("arst_cnt", pulse_cnt, 0);
    check("arst_done", done_sig, 1);
    check("arst_tmo", timeout_sig, 0);
    check("arst_per", last_period, 0);
    check("arst_m3_cnt", pulse_cnt3, 0);
    in_sig = 1'b0;
    @(negedge sys_clk); rst_n = 1'b1;
    tick(3);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done_sig, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
